// File: rtl/qk_accum_pkg.sv
// rtl/qk_accum_pkg.sv - shared types, default widths and output formatting for the Q*K accumulator
package qk_accum_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CH        = 16;
  localparam int DEF_FRAC_BITS = 8;
  localparam int DEF_ACC_W     = 32;
  localparam int DEF_OUT_W     = 16;
  localparam int DEF_SAT_EN    = 1;
  localparam int DEF_MAX_BEATS = 16;
  localparam int DEF_CW        = $clog2(DEF_MAX_BEATS + 1);

  // Formatting works on a wide signed value so one function serves any ACC_W/OUT_W <= 64
  localparam int FMT_W = 64;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } acc_state_t;

  typedef struct packed {
    logic             ovf;
    logic [FMT_W-1:0] value;
  } fmt_t;

  // Range-check a sum against a signed out_w-bit window; clamp or wrap, and flag overflow either way
  function automatic fmt_t sat_fmt(input logic signed [FMT_W-1:0] sum,
                                   input int out_w,
                                   input bit sat_en);
    logic signed [FMT_W-1:0] hi;
    logic signed [FMT_W-1:0] lo;
    fmt_t r;
    hi = $signed((64'd1 << (out_w - 1)) - 64'd1);
    lo = ~hi;
    r.ovf   = (sum > hi) || (sum < lo);
    r.value = sum;
    if (sat_en && (sum > hi)) begin
      r.value = hi;
    end else if (sat_en && (sum < lo)) begin
      r.value = lo;
    end
    return r;
  endfunction

endpackage

// File: rtl/qk_lane_combine.sv
// rtl/qk_lane_combine.sv - one channel: combined partial-product term, running sum and output format
module qk_lane_combine
  import qk_accum_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int SAT_EN    = DEF_SAT_EN
) (
  input  logic signed [2*WIDTH-1:0] int_p,
  input  logic signed [2*WIDTH-1:0] frac1,
  input  logic signed [2*WIDTH-1:0] frac2,
  input  logic signed [ACC_W-1:0]   acc,
  input  logic                      open,
  output logic signed [ACC_W-1:0]   sum,
  output logic        [OUT_W-1:0]   fmt_val,
  output logic                      fmt_ovf
);

  logic signed [ACC_W-1:0] term;
  fmt_t                    fmt_r;
  logic                    unused_hi;

  // Sign-extend all three products to ACC_W, align the Int product, add onto the open accumulator
  always_comb begin
    term      = (ACC_W'(int_p) <<< FRAC_BITS) + ACC_W'(frac1) + ACC_W'(frac2);
    sum       = (open ? acc : '0) + term;
    fmt_r     = sat_fmt(FMT_W'(sum), OUT_W, SAT_EN != 0);
    fmt_val   = fmt_r.value[OUT_W-1:0];
    fmt_ovf   = fmt_r.ovf;
    unused_hi = ^fmt_r.value[FMT_W-1:OUT_W];
  end

endmodule

// File: rtl/qk_partial_accum.sv
// rtl/qk_partial_accum.sv - multi-beat Q*K partial-product accumulator with valid/ready result register
module qk_partial_accum
  import qk_accum_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CH        = DEF_CH,
  parameter int FRAC_BITS = DEF_FRAC_BITS,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int OUT_W     = DEF_OUT_W,
  parameter int SAT_EN    = DEF_SAT_EN,
  parameter int MAX_BEATS = DEF_MAX_BEATS
) (
  input  logic                               clk,
  input  logic                               _reset,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic                               in_last,
  input  logic [CH*2*WIDTH-1:0]              int_vec,
  input  logic [CH*2*WIDTH-1:0]              frac1_vec,
  input  logic [CH*2*WIDTH-1:0]              frac2_vec,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CH*OUT_W-1:0]                out_data,
  output logic [CH-1:0]                      out_sat,
  output logic [$clog2(MAX_BEATS+1)-1:0]     beat_cnt,
  output logic                               err
);

  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam int PW = 2 * WIDTH;

  acc_state_t                   state;
  acc_state_t                   state_nxt;
  logic [CH-1:0][ACC_W-1:0]     acc;
  logic [CH-1:0][ACC_W-1:0]     sum;
  logic [CH-1:0][OUT_W-1:0]     fmt_val;
  logic [CH-1:0]                fmt_ovf;
  logic                         open;
  logic                         accept;
  logic                         force_close;
  logic                         close;
  logic [CW-1:0]                cnt_inc;

  assign open        = (state == ST_ACCUM);
  // Combinational ready lets a beat land in the same cycle the pending result drains
  assign in_ready    = !flush && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign cnt_inc     = beat_cnt + 1'b1;
  assign force_close = (cnt_inc == CW'(MAX_BEATS));
  assign close       = accept && (in_last || force_close);

  for (genvar i = 0; i < CH; i++) begin : g_lane
    qk_lane_combine #(
      .WIDTH     (WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .ACC_W     (ACC_W),
      .OUT_W     (OUT_W),
      .SAT_EN    (SAT_EN)
    ) u_lane (
      .int_p   (int_vec[i*PW +: PW]),
      .frac1   (frac1_vec[i*PW +: PW]),
      .frac2   (frac2_vec[i*PW +: PW]),
      .acc     (acc[i]),
      .open    (open),
      .sum     (sum[i]),
      .fmt_val (fmt_val[i]),
      .fmt_ovf (fmt_ovf[i])
    );
  end

  // Packet state register
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next packet state: open on a non-closing beat, return to idle on close or flush
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else if (accept) begin
      state_nxt = close ? ST_IDLE : ST_ACCUM;
    end
  end

  // Accumulators, beat counter and sticky forced-close error
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      acc      <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else if (flush) begin
      acc      <= '0;
      beat_cnt <= '0;
      err      <= 1'b0;
    end else if (accept) begin
      if (close) begin
        acc      <= '0;
        beat_cnt <= '0;
        if (!in_last) begin
          err <= 1'b1;
        end
      end else begin
        acc      <= sum;
        beat_cnt <= cnt_inc;
      end
    end
  end

  // Result register: a closing beat loads it, otherwise it drains on out_ready
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= '0;
    end else if (close) begin
      out_valid <= 1'b1;
      out_data  <= fmt_val;
      out_sat   <= fmt_ovf;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: doc/qk_partial_accum.md
Name: qk_partial_accum

Overview:
- Parametrised successor to the Q*K partial-product adder.
- Per channel, combines the integer partial product with two fractional partial products: (Int <<< FRAC_BITS) + Frac1 + Frac2.
- Accumulates that combined term over a multi-beat packet, covering the K dimension split into beats.
- At packet end, emits a saturated or wrapped fixed-point score per channel through a valid/ready output register.
- Sits between the Q/K multiplier arrays and the softmax front end.

Parameters:
- WIDTH, 8: operand width; each partial-product input is 2*WIDTH bits, signed.
- CH, 16: number of parallel channels.
- FRAC_BITS, 8: left shift applied to the Int product.
- ACC_W, 32: accumulator width per channel, signed.
- OUT_W, 16: output width per channel, signed.
- SAT_EN, 1: 1 = clamp to OUT_W range; 0 = keep the low OUT_W bits (wrap).
- MAX_BEATS, 16: maximum beats per packet. CW = $clog2(MAX_BEATS+1).

Ports:
- clk  in  1  clock
- _reset  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous discard of the open packet and clear of err
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid && in_ready
- in_last  in  1  final beat of packet
- int_vec  in  CH*2*WIDTH  packed Int products, channel 0 at LSBs
- frac1_vec  in  CH*2*WIDTH  packed Frac1 products
- frac2_vec  in  CH*2*WIDTH  packed Frac2 products
- out_valid  out  1  result register full
- out_ready  in  1  downstream accepts
- out_data  out  CH*OUT_W  packed results
- out_sat  out  CH  per-channel overflow indicator for out_data
- beat_cnt  out  CW  beats accumulated in the open packet
- err  out  1  sticky: packet force-closed at MAX_BEATS

Behaviour:
- Reset values: out_valid=0, out_data=0, out_sat=0, beat_cnt=0, err=0, accumulators=0, open=0.
- Handshake:
  - in_ready = !flush && (!out_valid || out_ready). This is combinational, so a beat can be accepted in the same cycle the output drains.
  - out_valid/out_data hold stable while out_valid && !out_ready.
  - out_valid clears on out_ready unless a new result loads in the same cycle; load wins.
- Term arithmetic per channel:
  - term = sext_ACC_W(Int) <<< FRAC_BITS + sext_ACC_W(Frac1) + sext_ACC_W(Frac2).
  - Computed in ACC_W; accumulator overflow beyond ACC_W wraps silently.
- Accumulator state:
  - IDLE (open=0) -> ACCUM (open=1) on an accepted beat with !last and beat_cnt+1 < MAX_BEATS.
  - Each accepted beat: sum = (open ? acc : 0) + term; beat_cnt increments.
- Close: an accepted beat with in_last, or the beat making beat_cnt+1 == MAX_BEATS.
  - Next edge: out_data = fmt(sum), out_sat set, out_valid=1.
  - Accumulator cleared, beat_cnt=0, open=0.
  - Forced close without in_last sets err=1.
- Latency: result visible 1 cycle after the closing beat is accepted. A single-beat packet (first beat has in_last) yields fmt(term).
- fmt:
  - out_sat[i] = 1 when sum is outside [-2^(OUT_W-1), 2^(OUT_W-1)-1], in both modes.
  - SAT_EN=1: clamp to that range.
  - SAT_EN=0: sum[OUT_W-1:0].
- flush: clears acc, beat_cnt, open and err next edge; does not touch a pending out register. Because in_ready=0 during flush, no beat is lost ambiguously.
- Async reset mid-packet: everything returns to reset values immediately; the partial packet is lost.

Decomposition:
- Package qk_accum_pkg:
  - localparams for default widths and CW computation.
  - Function sat_fmt(sum, OUT_W, SAT_EN) returning value plus overflow flag.
- Sub-module qk_lane_combine, one per channel via generate:
  - Combinational: term, next sum and fmt for one lane.
  - Top level owns the FSM, beat_cnt, handshakes and registers.

Test Plan:
- Single beat: Int=0x0001, F1=0x0010, F2=0x0020, last=1 -> next cycle out_valid=1, out_data lane=0x0130, out_sat=0.
- Three beats Int=0x0002, F=0, last on third -> out=0x0600 one cycle after beat 3; beat_cnt 1,2 then 0.
- Saturation: two beats Int=0x007F -> sum 0xFE00 (65024):
  - SAT_EN=1: out=0x7FFF, out_sat=1.
  - SAT_EN=0: out=0xFE00, out_sat=1.
- Backpressure: result pending, out_ready=0, in_valid=1 -> in_ready=0, out_data stable. Raise out_ready -> old result drains and the new beat is accepted in the same cycle.
- MAX_BEATS=4: four beats Int=1, no last -> out=0x0400 after beat 4, err=1. flush for 1 cycle -> err=0, in_ready=0 during flush.
- Assert _reset after two beats -> all outputs 0. A new single-beat packet Int=1 -> out=0x0100 with no residue.
